shift_op_sequencer: RTL and testbench

//  Controller that shares one external 32-bit barrel shifter (SHIFT32) between N_REQ requesters.

---
 rtl/shift_op_sequencer_pkg.sv | 35 +++
 rtl/shift_op_sequencer_if.sv | 34 +++
 rtl/shift_op_sequencer_rr_arbiter.sv | 40 ++++
 rtl/shift_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_shift_op_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_op_sequencer_pkg.sv
// Shared types and helpers for the shift operation sequencer: opcodes, FSM states
// and the rule deciding whether an operation needs a second shifter pass.
package shift_op_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_DONE
  } state_e;

  function automatic logic isReserved(logic [2:0] op);
    return op > 3'd4;
  endfunction

  // SRA fills the vacated top bits with a second pass; rotates merge the wrapped part.
  function automatic logic needsSecondPass(logic [2:0] op, logic dataMsb, logic [31:0] amt);
    case (op)
      OP_SRA:         return (amt != 32'd0) && (amt < 32'd32) && dataMsb;
      OP_ROL, OP_ROR: return amt[4:0] != 5'd0;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_op_sequencer_if.sv
// Request, result and shared-shifter buses of the shift operation sequencer.
// slave = sequencer side, master = clients plus the external shifter.
interface shift_op_sequencer_if
  import shift_op_sequencer_pkg::*;
#(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]        reqValid;
  logic [3*N_REQ-1:0]      reqOp;
  logic [DATA_W*N_REQ-1:0] reqD;
  logic [DATA_W*N_REQ-1:0] reqS;
  logic [N_REQ-1:0]        reqGnt;

  logic                    resValid;
  logic                    resReady;
  logic [DATA_W-1:0]       resData;
  logic [1:0]              resId;
  logic                    resErr;

  logic [DATA_W-1:0]       shD;
  logic [DATA_W-1:0]       shS;
  logic                    shLnr;
  logic [DATA_W-1:0]       shY;

  modport slave (
    input  reqValid, reqOp, reqD, reqS, resReady, shY,
    output reqGnt, resValid, resData, resId, resErr, shD, shS, shLnr
  );

  modport master (
    output reqValid, reqOp, reqD, reqS, resReady, shY,
    input  reqGnt, resValid, resData, resId, resErr, shD, shS, shLnr
  );
endinterface

// File: rtl/shift_op_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the pointer,
// pointer moves to the winner when the grant is accepted.
module shift_op_sequencer_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       gntId_o
);

  logic [1:0] ptr_q, ptr_d;
  logic       found;

  always_comb begin
    gnt_o   = '0;
    gntId_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (en_i && !found && req_i[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + N_REQ))) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          gntId_o  = 2'(i);
        end
      end
    end
    ptr_d = accept_i ? gntId_o : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 2'(N_REQ - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_op_sequencer.sv
// Shares one external logical barrel shifter between N_REQ clients, building
// SLL/SRL/SRA/ROL/ROR from one or two shifter passes, one operation in flight.
module shift_op_sequencer
  import shift_op_sequencer_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  shift_op_sequencer_if.slave  bus,
  output logic                 busy_o
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] amt_q, amt_d;
  logic [1:0]        id_q, id_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] resData_q, resData_d;
  logic              resErr_q, resErr_d;

  logic [N_REQ-1:0]  gnt;
  logic [1:0]        gntId;
  logic              fire;
  logic [2:0]        opSel;
  logic [DATA_W-1:0] dSel, sSel;
  logic [DATA_W-1:0] shD, shS;
  logic              shLnr;

  shift_op_sequencer_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     ((state_q == ST_IDLE) && !rst_i),
    .req_i    (bus.reqValid),
    .accept_i (fire),
    .gnt_o    (gnt),
    .gntId_o  (gntId)
  );

  assign fire = |(bus.reqValid & gnt);

  always_comb begin
    opSel = '0;
    dSel  = '0;
    sSel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gntId == 2'(i)) begin
        opSel = bus.reqOp[3*i +: 3];
        dSel  = bus.reqD[DATA_W*i +: DATA_W];
        sSel  = bus.reqS[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    amt_d     = amt_q;
    id_d      = id_q;
    acc_d     = acc_q;
    resData_d = resData_q;
    resErr_d  = resErr_q;
    shD       = '0;
    shS       = '0;
    shLnr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          op_d     = opSel;
          data_d   = dSel;
          amt_d    = sSel;
          id_d     = gntId;
          resErr_d = 1'b0;
          if (isReserved(opSel)) begin
            resData_d = dSel;
            resErr_d  = 1'b1;
            state_d   = ST_DONE;
          end else if (opSel == OP_SRA && sSel >= 32'd32) begin
            resData_d = {DATA_W{dSel[DATA_W-1]}};
            state_d   = ST_DONE;
          end else begin
            state_d = ST_PASS1;
          end
        end
      end
      ST_PASS1: begin
        shD   = data_q;
        shLnr = (op_q == OP_SLL) || (op_q == OP_ROL);
        shS   = ((op_q == OP_ROL) || (op_q == OP_ROR)) ? {27'd0, amt_q[4:0]} : amt_q;
        acc_d = bus.shY;
        if (needsSecondPass(op_q, data_q[DATA_W-1], amt_q)) begin
          state_d = ST_PASS2;
        end else begin
          resData_d = bus.shY;
          state_d   = ST_DONE;
        end
      end
      ST_PASS2: begin
        // Second pass supplies the sign fill (SRA) or the wrapped-around bits (rotates).
        if (op_q == OP_SRA) begin
          shD   = '1;
          shS   = 32'd32 - amt_q;
          shLnr = 1'b1;
        end else begin
          shD   = data_q;
          shS   = 32'd32 - {27'd0, amt_q[4:0]};
          shLnr = (op_q == OP_ROR);
        end
        resData_d = acc_q | bus.shY;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.resReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      data_q    <= '0;
      amt_q     <= '0;
      id_q      <= '0;
      acc_q     <= '0;
      resData_q <= '0;
      resErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      amt_q     <= amt_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      resData_q <= resData_d;
      resErr_q  <= resErr_d;
    end
  end

  assign bus.reqGnt   = gnt;
  assign bus.resValid = (state_q == ST_DONE);
  assign bus.resData  = resData_q;
  assign bus.resId    = id_q;
  assign bus.resErr   = resErr_q;
  assign bus.shD      = shD;
  assign bus.shS      = shS;
  assign bus.shLnr    = shLnr;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Bench for shift_op_sequencer: behavioural SHIFT32 on the shifter bus and a
// reference model computing results, latency and round-robin order from the rules.
module tb_shift_op_sequencer;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   ptrModel;

  always #5 clk = ~clk;

  shift_op_sequencer_if #(.N_REQ(N)) sif ();

  shift_op_sequencer #(.N_REQ(N)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (sif),
    .busy_o (busy)
  );

  assign sif.shY = (sif.shS >= 32'd32) ? 32'd0 :
                   (sif.shLnr ? (sif.shD << sif.shS[4:0]) : (sif.shD >> sif.shS[4:0]));

  function automatic logic [31:0] refResult(logic [2:0] op, logic [31:0] d, logic [31:0] s);
    int r;
    r = int'(s[4:0]);
    case (op)
      3'd0: return (s >= 32) ? 32'd0 : (d << s);
      3'd1: return (s >= 32) ? 32'd0 : (d >> s);
      3'd2: return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s);
      3'd3: return (r == 0) ? d : ((d << r) | (d >> (32 - r)));
      3'd4: return (r == 0) ? d : ((d >> r) | (d << (32 - r)));
      default: return d;
    endcase
  endfunction

  function automatic int refLatency(logic [2:0] op, logic [31:0] d, logic [31:0] s);
    if (op > 3'd4) return 1;
    if (op == 3'd2) begin
      if (s >= 32) return 1;
      return (s != 0 && d[31]) ? 3 : 2;
    end
    if (op == 3'd3 || op == 3'd4) return (s[4:0] != 0) ? 3 : 2;
    return 2;
  endfunction

  function automatic int refWinner(logic [N-1:0] v, int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction from requester idx, optionally stalling the consumer.
  task automatic applyStimulus(int idx, logic [2:0] op, logic [31:0] d, logic [31:0] s, int hold);
    int lat;
    logic [31:0] expData;
    int other;
    other   = (idx + 1) % N;
    expData = refResult(op, d, s);
    sif.reqValid = '0;
    sif.reqValid[idx] = 1'b1;
    sif.reqOp[3*idx +: 3] = op;
    sif.reqD[32*idx +: 32] = d;
    sif.reqS[32*idx +: 32] = s;
    #1;
    checkOutput("grant", 32'(sif.reqGnt), 32'(1 << idx));
    ptrModel = idx;
    @(posedge clk); #1;
    sif.reqValid = '0;
    lat = 1;
    while (!sif.resValid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(refLatency(op, d, s)));
    checkOutput("resData", sif.resData, expData);
    checkOutput("resId", 32'(sif.resId), 32'(idx));
    checkOutput("resErr", 32'(sif.resErr), 32'(op > 3'd4));
    for (int h = 0; h < hold; h++) begin
      sif.reqValid[other] = 1'b1;
      @(posedge clk); #1;
      checkOutput("holdValid", 32'(sif.resValid), 32'd1);
      checkOutput("holdData", sif.resData, expData);
      checkOutput("holdNoGnt", 32'(sif.reqGnt), 32'd0);
      checkOutput("holdShD", sif.shD, 32'd0);
    end
    sif.reqValid = '0;
    sif.resReady = 1'b1;
    @(posedge clk); #1;
    sif.resReady = 1'b0;
    checkOutput("validDrop", 32'(sif.resValid), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    int results;
    int expId[$];
    int w;
    logic [2:0] rop;
    logic [31:0] rd, rs;

    $display("[TB] start");
    rst = 1'b1;
    sif.reqValid = 2'b11;
    sif.reqOp = '0;
    sif.reqD = '0;
    sif.reqS = '0;
    sif.resReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstGnt", 32'(sif.reqGnt), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstValid", 32'(sif.resValid), 32'd0);
    checkOutput("rstData", sif.resData, 32'd0);
    checkOutput("rstId", 32'(sif.resId), 32'd0);
    checkOutput("rstErr", 32'(sif.resErr), 32'd0);
    checkOutput("rstShD", sif.shD, 32'd0);
    checkOutput("rstShS", sif.shS, 32'd0);
    checkOutput("rstShLnr", 32'(sif.shLnr), 32'd0);
    sif.reqValid = '0;
    rst = 1'b0;
    ptrModel = N - 1;
    @(posedge clk); #1;

    applyStimulus(0, 3'd0, 32'h0000_0001, 32'd31, 0);
    applyStimulus(1, 3'd2, 32'h8000_0000, 32'd4, 0);
    applyStimulus(0, 3'd2, 32'h8000_0000, 32'd40, 0);
    applyStimulus(1, 3'd4, 32'h1234_5678, 32'd8, 5);
    applyStimulus(0, 3'd3, 32'h1234_5678, 32'd32, 0);
    applyStimulus(1, 3'd7, 32'hDEAD_BEEF, 32'd3, 0);
    applyStimulus(0, 3'd1, 32'hF000_0000, 32'd32, 0);
    applyStimulus(1, 3'd2, 32'h7000_0000, 32'd5, 0);

    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = $urandom;
      rs  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      applyStimulus(int'($urandom_range(0, N - 1)), rop, rd, rs, int'($urandom_range(0, 2)));
    end

    $display("[TB] fairness with both requesters valid");
    sif.reqOp[2:0]   = 3'd0;
    sif.reqD[31:0]   = 32'h0000_0003;
    sif.reqS[31:0]   = 32'd2;
    sif.reqOp[5:3]   = 3'd3;
    sif.reqD[63:32]  = 32'h8000_0001;
    sif.reqS[63:32]  = 32'd1;
    sif.reqValid     = 2'b11;
    sif.resReady     = 1'b1;
    results = 0;
    #1;
    for (int cyc = 0; cyc < 100 && results < 6; cyc++) begin
      if (sif.reqGnt != '0) begin
        w = refWinner(2'b11, ptrModel);
        checkOutput("rrGnt", 32'(sif.reqGnt), 32'(1 << w));
        ptrModel = w;
        expId.push_back(w);
      end
      if (sif.resValid) begin
        w = (expId.size() > 0) ? expId.pop_front() : -1;
        checkOutput("rrId", 32'(sif.resId), 32'(w));
        checkOutput("rrData", sif.resData,
                    (w == 0) ? refResult(3'd0, 32'h0000_0003, 32'd2)
                             : refResult(3'd3, 32'h8000_0001, 32'd1));
        results++;
      end
      if (results < 6) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rrCount", 32'(results), 32'd6);
    sif.reqValid = '0;
    @(posedge clk); #1;
    sif.resReady = 1'b0;
    checkOutput("rrIdle", 32'(busy), 32'd0);

    $display("[TB] reset during second pass");
    sif.reqValid = 2'b01;
    sif.reqOp[2:0] = 3'd2;
    sif.reqD[31:0] = 32'h8000_0000;
    sif.reqS[31:0] = 32'd4;
    #1;
    checkOutput("rstOpGnt", 32'(sif.reqGnt), 32'd1);
    @(posedge clk); #1;
    sif.reqValid = '0;
    @(posedge clk); #1;
    checkOutput("pass2Busy", 32'(busy), 32'd1);
    checkOutput("pass2ShLnr", 32'(sif.shLnr), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstValid", 32'(sif.resValid), 32'd0);
    rst = 1'b0;
    ptrModel = N - 1;
    sif.reqValid = 2'b11;
    #1;
    checkOutput("ptrReinit", 32'(sif.reqGnt), 32'(1 << refWinner(2'b11, ptrModel)));
    sif.reqValid = '0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
